prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 32 +++
 rtl/prog_loader.sv | 115 +++++++++++
 tb/tb_prog_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Bus bundle between the program loader and its environment: load control,
// byte source handshake and CPU-bus / RAM control strobes.
interface prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] bus_out;
  logic              bus_drive;
  logic              mar_load;
  logic              ram_we;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;

  modport master (
    output start, abort, base_addr, len, in_valid, in_data,
    input  in_ready, bus_out, bus_drive, mar_load, ram_we, cpu_hold, busy, done, count
  );

  modport slave (
    input  start, abort, base_addr, len, in_valid, in_data,
    output in_ready, bus_out, bus_drive, mar_load, ram_we, cpu_hold, busy, done, count
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams bytes from a valid/ready source into CPU RAM through
// the shared bus, one address phase plus one write phase per byte.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   count_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   count_inc;

  assign len_clamped = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
  assign count_inc   = count_q + 1'b1;

  // NOTE: every register here gets a reset value, including datapath state,
  // so a reset mid-load leaves no stale address/length/byte behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: combinational blocks assign defaults first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.start) state_d = (len_clamped == '0) ? S_DONE : S_ADDR;
        S_ADDR:  state_d = S_WAIT;
        S_WAIT:  if (bus.in_valid) state_d = S_WRITE;
        S_WRITE: state_d = (count_inc == len_q) ? S_DONE : S_ADDR;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The WRITE-cycle updates happen even under abort: that byte reaches RAM.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          addr_q  <= bus.base_addr;
          len_q   <= len_clamped;
          count_q <= '0;
        end
        S_WAIT:  if (bus.in_valid) data_q <= bus.in_data;
        S_WRITE: begin
          addr_q  <= addr_q + 1'b1;
          count_q <= count_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.bus_out   = '0;
    bus.bus_drive = 1'b0;
    bus.mar_load  = 1'b0;
    bus.ram_we    = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.cpu_hold  = (state_q != S_IDLE);
    bus.count     = count_q;
    case (state_q)
      S_ADDR: begin
        bus.bus_drive = 1'b1;
        bus.bus_out   = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
        bus.mar_load  = 1'b1;
        bus.busy      = 1'b1;
      end
      S_WAIT: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      S_WRITE: begin
        bus.bus_drive = 1'b1;
        bus.bus_out   = data_q;
        bus.ram_we    = 1'b1;
        bus.busy      = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a negedge monitor logs bus address/write
// phases, linear steps compare them against hand-computed values.
module tb_prog_loader;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   viol;
  int   idx;
  int   cyc;
  int   m0;
  int   w0;

  logic [7:0] data_tbl[32];
  logic [3:0] mar_log[$];
  logic [3:0] we_addr_log[$];
  logic [7:0] we_data_log[$];
  logic [3:0] last_mar;

  prog_loader_if #(.ADDR_W(4), .DATA_W(8)) bus_if ();

  prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus observer: logs address/write phases and flags strobe overlap.
  always @(negedge clk) begin
    if (bus_if.mar_load) begin
      mar_log.push_back(bus_if.bus_out[3:0]);
      last_mar <= bus_if.bus_out[3:0];
      if (bus_if.bus_out[7:4] != 4'h0) viol <= viol + 1;
    end
    if (bus_if.ram_we) begin
      we_addr_log.push_back(last_mar);
      we_data_log.push_back(bus_if.bus_out);
    end
    if ((bus_if.mar_load && bus_if.ram_we) || (bus_if.mar_load && bus_if.in_ready) ||
        (bus_if.ram_we && bus_if.in_ready) ||
        (!bus_if.bus_drive && (bus_if.mar_load || bus_if.ram_we || bus_if.bus_out != 8'h00)))
      viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [3:0] b, input logic [4:0] l);
    bus_if.base_addr = b;
    bus_if.len       = l;
    bus_if.start     = 1'b1;
    idx              = 0;
    m0               = mar_log.size();
    w0               = we_data_log.size();
    tick();
    bus_if.start     = 1'b0;
    bus_if.base_addr = ~b;
    bus_if.len       = 5'd7;
  endtask

  // Runs until done (cycle 1 is the first cycle after the start edge).
  task automatic run_to_done(input int maxc, output int c);
    bit acc;
    c = 1;
    while (!bus_if.done && c < maxc) begin
      bus_if.in_data = data_tbl[idx % 32];
      acc = bus_if.in_ready && bus_if.in_valid;
      tick();
      if (acc) idx++;
      c++;
    end
    check("done_seen", {31'd0, bus_if.done}, 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0; viol = 0; idx = 0; last_mar = '0;
    for (int i = 0; i < 32; i++) data_tbl[i] = 8'(8'h40 + i);
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.base_addr = '0;
    bus_if.len = '0; bus_if.in_valid = 1'b0; bus_if.in_data = '0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_in_ready",  {31'd0, bus_if.in_ready},  0);
    check("rst_bus_drive", {31'd0, bus_if.bus_drive}, 0);
    check("rst_cpu_hold",  {31'd0, bus_if.cpu_hold},  0);
    check("rst_busy",      {31'd0, bus_if.busy},      0);
    check("rst_done",      {31'd0, bus_if.done},      0);
    check("rst_bus_out",   {24'd0, bus_if.bus_out},   0);
    check("rst_count",     {27'd0, bus_if.count},     0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // base 2, len 3, valid held
    data_tbl[0] = 8'h1E; data_tbl[1] = 8'h2F; data_tbl[2] = 8'hE0;
    bus_if.in_valid = 1'b1;
    start_load(4'd2, 5'd3);
    check("l3_cpu_hold", {31'd0, bus_if.cpu_hold}, 1);
    run_to_done(40, cyc);
    check("l3_done_cycle", cyc, 10);
    check("l3_count", {27'd0, bus_if.count}, 3);
    check("l3_mar_n", mar_log.size() - m0, 3);
    check("l3_mar0", {28'd0, mar_log[m0]},   2);
    check("l3_mar1", {28'd0, mar_log[m0+1]}, 3);
    check("l3_mar2", {28'd0, mar_log[m0+2]}, 4);
    check("l3_we_n", we_data_log.size() - w0, 3);
    check("l3_we0", {24'd0, we_data_log[w0]},   32'h1E);
    check("l3_we1", {24'd0, we_data_log[w0+1]}, 32'h2F);
    check("l3_we2", {24'd0, we_data_log[w0+2]}, 32'hE0);
    tick();
    check("l3_idle_hold", {31'd0, bus_if.cpu_hold}, 0);
    check("l3_count_kept", {27'd0, bus_if.count}, 3);

    // Address wrap: base 14, len 4
    data_tbl[0] = 8'h11; data_tbl[1] = 8'h22; data_tbl[2] = 8'h33; data_tbl[3] = 8'h44;
    start_load(4'd14, 5'd4);
    run_to_done(40, cyc);
    check("wr_done_cycle", cyc, 13);
    check("wr_count", {27'd0, bus_if.count}, 4);
    check("wr_we_n", we_data_log.size() - w0, 4);
    check("wr_a0", {28'd0, we_addr_log[w0]},   14);
    check("wr_a1", {28'd0, we_addr_log[w0+1]}, 15);
    check("wr_a2", {28'd0, we_addr_log[w0+2]}, 0);
    check("wr_a3", {28'd0, we_addr_log[w0+3]}, 1);
    check("wr_d3", {24'd0, we_data_log[w0+3]}, 32'h44);
    tick();

    // len 0 -> immediate DONE
    start_load(4'd5, 5'd0);
    check("l0_done", {31'd0, bus_if.done}, 1);
    check("l0_cpu_hold", {31'd0, bus_if.cpu_hold}, 1);
    check("l0_busy", {31'd0, bus_if.busy}, 0);
    check("l0_count", {27'd0, bus_if.count}, 0);
    tick();
    check("l0_no_mar", mar_log.size() - m0, 0);
    check("l0_no_we", we_data_log.size() - w0, 0);

    // len 20 clamps to 16
    for (int i = 0; i < 32; i++) data_tbl[i] = 8'(8'h40 + i);
    start_load(4'd0, 5'd20);
    run_to_done(100, cyc);
    check("cl_done_cycle", cyc, 49);
    check("cl_count", {27'd0, bus_if.count}, 16);
    check("cl_we_n", we_data_log.size() - w0, 16);
    check("cl_last_addr", {28'd0, we_addr_log[w0+15]}, 15);
    check("cl_last_data", {24'd0, we_data_log[w0+15]}, 32'h4F);
    tick();

    // Source stalls 5 cycles in WAIT
    bus_if.in_valid = 1'b0;
    start_load(4'd5, 5'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("st_in_ready", {31'd0, bus_if.in_ready}, 1);
      check("st_no_we", {31'd0, bus_if.ram_we}, 0);
      tick();
    end
    check("st_still_wait", {31'd0, bus_if.in_ready}, 1);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h5A;
    tick();
    check("st_we", {31'd0, bus_if.ram_we}, 1);
    check("st_we_data", {24'd0, bus_if.bus_out}, 32'h5A);
    tick();
    check("st_done", {31'd0, bus_if.done}, 1);
    check("st_count", {27'd0, bus_if.count}, 1);
    tick();

    // Abort in second WAIT; start while busy ignored
    bus_if.in_data = 8'h77;
    start_load(4'd8, 5'd4);
    bus_if.start = 1'b1;
    bus_if.base_addr = 4'd0;
    tick();
    tick();
    tick();
    bus_if.start = 1'b0;
    tick();
    check("ab_in_wait", {31'd0, bus_if.in_ready}, 1);
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    check("ab_cpu_hold", {31'd0, bus_if.cpu_hold}, 0);
    check("ab_busy", {31'd0, bus_if.busy}, 0);
    check("ab_no_done", {31'd0, bus_if.done}, 0);
    check("ab_count", {27'd0, bus_if.count}, 1);
    check("ab_mar1", {28'd0, mar_log[m0+1]}, 9);
    tick();
    check("ab_no_done_late", {31'd0, bus_if.done}, 0);
    check("ab_we_n", we_data_log.size() - w0, 1);

    // Reset during WRITE of byte 2
    bus_if.in_data = 8'hA1;
    start_load(4'd3, 5'd3);
    repeat (5) tick();
    check("rw_in_write", {31'd0, bus_if.ram_we}, 1);
    #2 rst = 1'b0;
    #1;
    check("rw_we", {31'd0, bus_if.ram_we}, 0);
    check("rw_bus_drive", {31'd0, bus_if.bus_drive}, 0);
    check("rw_cpu_hold", {31'd0, bus_if.cpu_hold}, 0);
    check("rw_bus_out", {24'd0, bus_if.bus_out}, 0);
    check("rw_count", {27'd0, bus_if.count}, 0);
    repeat (2) tick();
    check("rw_we_n", we_data_log.size() - w0, 1);
    rst = 1'b1;
    tick();
    data_tbl[0] = 8'hC3; data_tbl[1] = 8'h3C;
    start_load(4'd3, 5'd2);
    run_to_done(40, cyc);
    check("rc_done_cycle", cyc, 7);
    check("rc_count", {27'd0, bus_if.count}, 2);
    check("rc_a0", {28'd0, we_addr_log[w0]}, 3);
    check("rc_a1", {28'd0, we_addr_log[w0+1]}, 4);
    check("rc_d1", {24'd0, we_data_log[w0+1]}, 32'h3C);
    tick();

    check("strobe_exclusive", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
